// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus of the data-memory port arbiter.
//   req/req_we/req_addr/req_wdata : packed per-requester request fields
//   gnt                           : one-hot combinational grant
//   rsp_valid/rsp_rdata           : registered read response, data shared by all requesters
// Modports: master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the write port and read port 1 of the data memory between
// NUM_REQ requesters, plus a scrub sequencer that zeroes every address, one per cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus           : requester handshake (dmem_port_arbiter_if.slave)
//   scrub_start   : pulse, starts a full-memory zeroing pass
//   scrub_busy    : high for every scrub cycle
//   mem_we/mem_waddr/mem_wdata : memory write port
//   mem_raddr/mem_rdata        : memory read port 1 (combinational read)
//   grant_count   : per-requester saturating 8-bit grant counters (only with DMEM_ARB_STATS_EN)
// Optional feature macro: DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus,
  input  logic                scrub_start,
  output logic                scrub_busy,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_count
`endif
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StScrub} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     rr_q;
  logic [PtrW-1:0]     gnt_idx;
  logic [PtrW-1:0]     rr_nxt;
  logic                gnt_any;
  logic [NUM_REQ-1:0]  gnt_c;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [ADDR_W-1:0]   scrub_addr_q;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  // Reset gates the grant and the memory strobes so a reset mid-scrub writes nothing more.
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!reset && state_q == StIdle) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_q) + k) % NUM_REQ;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx[PtrW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (gnt_any) begin
      gnt_c[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    sel_wdata = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
    sel_we    = bus.req_we[gnt_idx];
  end

  always_comb begin
    if (32'(gnt_idx) == NUM_REQ - 1) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (!reset && state_q == StScrub) begin
      mem_we    = 1'b1;
      mem_waddr = scrub_addr_q;
    end else if (gnt_any) begin
      if (sel_we) begin
        mem_we    = 1'b1;
        mem_waddr = sel_addr;
        mem_wdata = sel_wdata;
      end else begin
        mem_raddr = sel_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      scrub_addr_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (gnt_any) begin
        rr_q <= rr_nxt;
        if (!sel_we) begin
          rsp_valid_q <= gnt_c;
          rsp_rdata_q <= mem_rdata;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (scrub_start) begin
            state_q <= StScrub;
          end
        end
        StScrub: begin
          // Address wraps to 0 on the last write, leaving it ready for the next pass.
          scrub_addr_q <= scrub_addr_q + 1'b1;
          if (scrub_addr_q == '1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign scrub_busy    = (state_q == StScrub);
  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (gnt_c[k] && cnt_q[k] != 8'hFF) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant order, memory contents, scrub counter).
module tb_dmem_port_arbiter;
  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          scrub_start;
  logic          scrub_busy;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [NR*8-1:0] grant_count;
`endif

  dmem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .scrub_start (scrub_start),
    .scrub_busy  (scrub_busy),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  // 16x8 memory: write on posedge, combinational read.
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  // Reference model.
  int            m_rr;
  int            m_rem;  // scrub cycles still to run; 0 = idle
  logic [DW-1:0] m_mem [16];
  logic [NR-1:0] m_rsp_valid;
  logic [DW-1:0] m_rsp_rdata;

  int total = 0;
  int bad   = 0;

  function automatic int exp_grant(input logic [NR-1:0] rq);
    int i;
    if (m_rem > 0) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_rr + k) % NR;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply(input logic [NR-1:0] rq, input logic [NR-1:0] we,
                       input logic [NR*AW-1:0] addr, input logic [NR*DW-1:0] wd,
                       input logic ss);
    @(negedge clk);
    bus.req       = rq;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    scrub_start   = ss;
    #1;
  endtask

  // Advance the model by the cycle currently on the inputs, then clock the DUT.
  task automatic tick();
    int g;
    int a;
    g = exp_grant(bus.req);
    m_rsp_valid = '0;
    if (m_rem > 0) begin
      m_mem[16 - m_rem] = '0;
      m_rem--;
    end else begin
      if (g >= 0) begin
        a = int'(bus.req_addr[g*AW +: AW]);
        if (bus.req_we[g]) begin
          m_mem[a] = bus.req_wdata[g*DW +: DW];
        end else begin
          m_rsp_valid[g] = 1'b1;
          m_rsp_rdata    = m_mem[a];
        end
        m_rr = (g + 1) % NR;
      end
      if (scrub_start) m_rem = 16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    scrub_start   = 1'b0;
    repeat (2) @(posedge clk);
    m_rr        = 0;
    m_rem       = 0;
    m_rsp_valid = '0;
    m_rsp_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] val);
    for (int a = 0; a < 16; a++) begin
      apply(2'b01, 2'b01, {4'd0, 4'(a)}, {8'd0, val}, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", scrub_busy); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", bus.rsp_rdata); end
    total++; if ({mem_we, mem_waddr, mem_wdata, mem_raddr} !== 17'd0) begin
      bad++; $display("FAIL reset_mem_if: got we=%b wa=%h wd=%h ra=%h want all 0", mem_we, mem_waddr, mem_wdata, mem_raddr);
    end
  endtask

  task automatic test_write_read();
    apply(2'b01, 2'b01, 8'h03, 16'h00A5, 1'b0);
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", bus.gnt); end
    total++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 4'd3, 8'hA5}) begin
      bad++; $display("FAIL wr_port: got we=%b wa=%h wd=%h want 1 3 a5", mem_we, mem_waddr, mem_wdata);
    end
    tick();
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_no_rsp: got %b want 00", bus.rsp_valid); end
    apply(2'b01, 2'b00, 8'h03, 16'h0000, 1'b0);
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", bus.gnt); end
    total++; if ({mem_we, mem_raddr} !== {1'b0, 4'd3}) begin
      bad++; $display("FAIL rd_port: got we=%b ra=%h want 0 3", mem_we, mem_raddr);
    end
    tick();
    total++; if (bus.rsp_valid !== 2'b01) begin bad++; $display("FAIL rd_valid: got %b want 01", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", bus.rsp_rdata); end
    apply(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);
    tick();
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_valid_clear: got %b want 00", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data_hold: got %h want a5", bus.rsp_rdata); end
  endtask

  task automatic test_alternate();
    logic [NR-1:0] want;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      apply(2'b11, 2'b00, {4'd9, 4'd3}, 16'h0000, 1'b0);
      total++; if (bus.gnt !== want) begin bad++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, bus.gnt, want); end
      tick();
      total++; if (bus.rsp_valid !== want) begin bad++; $display("FAIL alt_valid[%0d]: got %b want %b", k, bus.rsp_valid, want); end
      total++; if (bus.rsp_rdata !== m_rsp_rdata) begin bad++; $display("FAIL alt_data[%0d]: got %h want %h", k, bus.rsp_rdata, m_rsp_rdata); end
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    apply(2'b10, 2'b00, 8'h00, 16'h0000, 1'b0);
    total++; if (bus.gnt !== 2'b10) begin bad++; $display("FAIL wrap_first: got %b want 10", bus.gnt); end
    tick();
    apply(2'b11, 2'b00, 8'h00, 16'h0000, 1'b0);
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL wrap_contested: got %b want 01", bus.gnt); end
    tick();
  endtask

  task automatic test_scrub();
    do_reset();
    fill(8'hFF);
    apply(2'b00, 2'b00, 8'h00, 16'h0000, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      // Requests and a repeated scrub_start are held throughout; both must be ignored.
      apply(2'b11, 2'b00, 8'h77, 16'h0000, 1'b1);
      total++; if (scrub_busy !== 1'b1) begin bad++; $display("FAIL scrub_busy[%0d]: got %b want 1", i, scrub_busy); end
      total++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 4'(i), 8'h00}) begin
        bad++; $display("FAIL scrub_port[%0d]: got we=%b wa=%h wd=%h want 1 %h 00", i, mem_we, mem_waddr, mem_wdata, 4'(i));
      end
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL scrub_gnt[%0d]: got %b want 00", i, bus.gnt); end
      tick();
    end
    // The fill left rr_ptr at 1, so requester 1 wins the first idle cycle.
    apply(2'b11, 2'b00, 8'h77, 16'h0000, 1'b0);
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL scrub_done: got %b want 0", scrub_busy); end
    total++; if (bus.gnt !== 2'b10) begin bad++; $display("FAIL scrub_post_gnt: got %b want 10", bus.gnt); end
    tick();
    for (int a = 0; a < 16; a++) begin
      apply(2'b01, 2'b00, {4'd0, 4'(a)}, 16'h0000, 1'b0);
      tick();
      total++; if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 8'h00}) begin
        bad++; $display("FAIL scrub_read[%0d]: got v=%b d=%h want 01 00", a, bus.rsp_valid, bus.rsp_rdata);
      end
    end
  endtask

  task automatic test_scrub_reset();
    logic [DW-1:0] want;
    do_reset();
    fill(8'hFF);
    apply(2'b00, 2'b00, 8'h00, 16'h0000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(2'b00, 2'b00, 8'h00, 16'h0000, 1'b0);
      tick();
    end
    do_reset();
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", scrub_busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL abort_we: got %b want 0", mem_we); end
    for (int a = 0; a < 16; a++) begin
      want = (a < 5) ? 8'h00 : 8'hFF;
      apply(2'b01, 2'b00, {4'd0, 4'(a)}, 16'h0000, 1'b0);
      tick();
      total++; if (bus.rsp_rdata !== want) begin bad++; $display("FAIL abort_read[%0d]: got %h want %h", a, bus.rsp_rdata, want); end
    end
  endtask

  task automatic test_random();
    logic          pend [NR];
    logic          p_we [NR];
    logic [AW-1:0] p_addr [NR];
    logic [DW-1:0] p_data [NR];
    logic [NR-1:0]    rq, we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wd;
    logic             ss;
    int               g;
    logic             e_we;
    logic [AW-1:0]    e_wa, e_ra;
    logic [DW-1:0]    e_wd;
    logic [NR-1:0]    e_gnt;
    do_reset();
    for (int r = 0; r < NR; r++) pend[r] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1) begin
          pend[r]   = 1'b1;
          p_we[r]   = 1'($urandom_range(1, 0));
          p_addr[r] = 4'($urandom_range(15, 0));
          p_data[r] = 8'($urandom_range(255, 0));
        end
        rq[r] = pend[r];
        we[r] = pend[r] & p_we[r];
        addr[r*AW +: AW] = p_addr[r];
        wd[r*DW +: DW]   = p_data[r];
      end
      ss = (m_rem == 0) && ($urandom_range(59, 0) == 0);
      apply(rq, we, addr, wd, ss);
      g = exp_grant(rq);
      e_gnt = '0; e_we = 1'b0; e_wa = '0; e_wd = '0; e_ra = '0;
      if (m_rem > 0) begin
        e_we = 1'b1;
        e_wa = 4'(16 - m_rem);
      end else if (g >= 0) begin
        e_gnt[g] = 1'b1;
        if (p_we[g]) begin
          e_we = 1'b1; e_wa = p_addr[g]; e_wd = p_data[g];
        end else begin
          e_ra = p_addr[g];
        end
      end
      total++; if (bus.gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, bus.gnt, e_gnt); end
      total++; if ({mem_we, mem_waddr, mem_wdata, mem_raddr} !== {e_we, e_wa, e_wd, e_ra}) begin
        bad++; $display("FAIL rnd_mem[%0d]: got %b %h %h %h want %b %h %h %h", c, mem_we, mem_waddr,
                        mem_wdata, mem_raddr, e_we, e_wa, e_wd, e_ra);
      end
      total++; if (scrub_busy !== (m_rem > 0)) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, scrub_busy, m_rem > 0); end
      tick();
      total++; if (bus.rsp_valid !== m_rsp_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.rsp_valid, m_rsp_valid); end
      total++; if (bus.rsp_rdata !== m_rsp_rdata) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.rsp_rdata, m_rsp_rdata); end
      if (g >= 0) pend[g] = 1'b0;
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    total++; if (grant_count !== 16'h0000) begin bad++; $display("FAIL stats_reset: got %h want 0000", grant_count); end
    for (int k = 0; k < 300; k++) begin
      apply(2'b01, 2'b01, 8'h00, 16'h0011, 1'b0);
      tick();
    end
    total++; if (grant_count[7:0] !== 8'd255) begin bad++; $display("FAIL stats_sat: got %0d want 255", grant_count[7:0]); end
    total++; if (grant_count[15:8] !== 8'd0) begin bad++; $display("FAIL stats_other: got %0d want 0", grant_count[15:8]); end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    scrub_start   = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_rr_wrap();
    test_scrub();
    test_scrub_reset();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
